// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable data width, runtime parity mode and stop length.
// Oversamples rx on s_tick; reports parity, framing and break status with each word.
module uart_rx_cfg #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned OVS     = 16,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      par_mode,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int unsigned SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int unsigned SW   = $clog2(SMAX);
  localparam int unsigned NW   = $clog2(DBIT);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HI
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic [1:0]      par_q;
  logic            perr_q;
  logic            ferr_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic            ferr_now;
  logic            par_en;

  // Stop sample and end of stop period can fall on the same tick (SB_TICK == OVS).
  assign ferr_now = (s_q == SW'(OVS - 1)) ? ~rx_s_q : ferr_q;
  assign par_en   = par_q[0] ^ par_q[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      par_q        <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_done_tick <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            s_q     <= '0;
            par_q   <= par_mode;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == SW'(OVS / 2 - 1)) begin
              if (rx_s_q) begin
                state_q <= IDLE;
              end else begin
                s_q     <= '0;
                n_q     <= '0;
                state_q <= DATA;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == SW'(OVS - 1)) begin
              s_q <= '0;
              b_q <= {rx_s_q, b_q[DBIT-1:1]};
              if (n_q == NW'(DBIT - 1)) begin
                state_q <= par_en ? PARITY : STOP;
              end else begin
                n_q <= n_q + 1'b1;
              end
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s_q == SW'(OVS - 1)) begin
              // Odd mode (10) inverts the even-parity check.
              perr_q  <= (^b_q) ^ rx_s_q ^ par_q[1];
              s_q     <= '0;
              state_q <= STOP;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s_q == SW'(OVS - 1)) begin
              ferr_q <= ~rx_s_q;
            end
            if (s_q == SW'(SB_TICK - 1)) begin
              s_q          <= '0;
              rx_done_tick <= 1'b1;
              dout         <= b_q;
              parity_err   <= perr_q;
              frame_err    <= ferr_now;
              break_det    <= (b_q == '0) && ferr_now;
              state_q      <= ferr_now ? WAIT_HI : IDLE;
            end else begin
              s_q <= s_q + 1'b1;
            end
          end
        end
        WAIT_HI: begin
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8-bit and a 7-bit instance checked every cycle
// against expected frame results queued by the stimulus.
module tb_uart_rx_cfg;

  localparam int unsigned OVS     = 16;
  localparam int unsigned BIT_CLK = 2 * OVS;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick  = 1'b0;
  logic       rx8     = 1'b1;
  logic       rx7     = 1'b1;
  logic [1:0] pm8     = 2'b00;
  logic [1:0] pm7     = 2'b00;
  logic [7:0] dout8;
  logic [6:0] dout7;
  logic       done8, done7, pe8, pe7, fe8, fe7, bk8, bk7;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  exp_t        q8[$];
  exp_t        q7[$];
  exp_t        last8 = '0;
  exp_t        last7 = '0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  uart_rx_cfg #(.DBIT(8), .OVS(OVS), .SB_TICK(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .rx(rx8), .s_tick(s_tick), .par_mode(pm8),
    .dout(dout8), .rx_done_tick(done8), .parity_err(pe8), .frame_err(fe8),
    .break_det(bk8)
  );

  uart_rx_cfg #(.DBIT(7), .OVS(OVS), .SB_TICK(16)) dut7 (
    .clk(clk), .reset_n(reset_n), .rx(rx7), .s_tick(s_tick), .par_mode(pm7),
    .dout(dout7), .rx_done_tick(done7), .parity_err(pe7), .frame_err(fe7),
    .break_det(bk7)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    s_tick = ~s_tick;
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: a synchronous reset clears expectations; otherwise each done pulse
  // must consume a queued frame, and outputs must hold the last frame's result.
  initial begin
    bit rst_seen;
    forever begin
      @(posedge clk);
      rst_seen = !reset_n;
      @(negedge clk);
      if (rst_seen) begin
        q8.delete();
        q7.delete();
        last8 = '0;
        last7 = '0;
        check("dut8_done_in_reset", {8'b0, done8}, 9'd0);
        check("dut7_done_in_reset", {8'b0, done7}, 9'd0);
      end else begin
        if (done8) begin
          check("dut8_done_queued", 9'(q8.size() > 0), 9'd1);
          if (q8.size() > 0) last8 = q8.pop_front();
        end
        if (done7) begin
          check("dut7_done_queued", 9'(q7.size() > 0), 9'd1);
          if (q7.size() > 0) last7 = q7.pop_front();
        end
      end
      check("dut8_dout", {1'b0, dout8}, last8.d);
      check("dut8_flags", {6'b0, pe8, fe8, bk8}, {6'b0, last8.pe, last8.fe, last8.bk});
      check("dut7_dout", {2'b0, dout7}, last7.d);
      check("dut7_flags", {6'b0, pe7, fe7, bk7}, {6'b0, last7.pe, last7.fe, last7.bk});
    end
  end

  task automatic drive(input bit k, input logic v);
    if (k) rx7 = v;
    else   rx8 = v;
  endtask

  task automatic hold_bits(input int unsigned nbits);
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  // k=0 targets the 8-bit instance, k=1 the 7-bit one. mode_mid is applied to par_mode
  // after the start bit; the expectation always follows the mode present at the start.
  task automatic send_frame(input bit k, input logic [8:0] d, input logic [1:0] mode,
                            input logic pbit, input logic stopv, input logic [1:0] mode_mid);
    exp_t        e;
    int unsigned nb;
    int unsigned ones;
    nb   = k ? 7 : 8;
    ones = $countones(d) + int'(pbit);
    e.d  = d;
    e.fe = !stopv;
    if (mode == 2'b01)      e.pe = (ones % 2) != 0;
    else if (mode == 2'b10) e.pe = (ones % 2) == 0;
    else                    e.pe = 1'b0;
    e.bk = (d == 9'd0) && e.fe;
    if (k) begin pm7 = mode; q7.push_back(e); end
    else   begin pm8 = mode; q8.push_back(e); end
    drive(k, 1'b0);
    hold_bits(1);
    if (k) pm7 = mode_mid;
    else   pm8 = mode_mid;
    for (int i = 0; i < int'(nb); i++) begin
      drive(k, d[i]);
      hold_bits(1);
    end
    if (mode == 2'b01 || mode == 2'b10) begin
      drive(k, pbit);
      hold_bits(1);
    end
    drive(k, stopv);
    hold_bits(1);
    drive(k, 1'b1);
    hold_bits(2);
  endtask

  initial begin
    exp_t brk;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("reset_dout8", {1'b0, dout8}, 9'h000);

    // Plain 8N1 frame.
    send_frame(0, 9'h0A5, 2'b00, 1'b0, 1'b1, 2'b00);
    check("t1_dout8", {1'b0, dout8}, 9'h0A5);
    check("t1_flags8", {6'b0, pe8, fe8, bk8}, 9'd0);

    // Even parity: good then bad parity bit; mid-frame mode change; mode 11 as none.
    send_frame(0, 9'h007, 2'b01, 1'b1, 1'b1, 2'b01);
    check("t2_pe_good", {8'b0, pe8}, 9'd0);
    send_frame(0, 9'h007, 2'b01, 1'b0, 1'b1, 2'b01);
    check("t2_pe_bad", {8'b0, pe8}, 9'd1);
    check("t2_dout8", {1'b0, dout8}, 9'h007);
    send_frame(0, 9'h007, 2'b01, 1'b1, 1'b1, 2'b10);
    check("t2_mode_latched", {8'b0, pe8}, 9'd0);
    send_frame(0, 9'h0E1, 2'b11, 1'b0, 1'b1, 2'b11);
    check("t2_mode11_dout", {1'b0, dout8}, 9'h0E1);

    // Odd parity on 7 data bits; framing error without break; zero data with good stop.
    send_frame(1, 9'h055, 2'b10, 1'b1, 1'b1, 2'b10);
    check("t3_pe7", {8'b0, pe7}, 9'd0);
    send_frame(1, 9'h055, 2'b10, 1'b1, 1'b0, 2'b10);
    check("t3_fe7", {8'b0, fe7}, 9'd1);
    check("t3_bk7", {8'b0, bk7}, 9'd0);
    send_frame(1, 9'h000, 2'b10, 1'b1, 1'b1, 2'b10);
    check("t3_zero_nobreak", {7'b0, fe7, bk7}, 9'd0);

    // Break: line held low for three frame times yields exactly one frame.
    brk = '{d: 9'd0, pe: 1'b0, fe: 1'b1, bk: 1'b1};
    pm8 = 2'b00;
    q8.push_back(brk);
    rx8 = 1'b0;
    repeat (3 * 10 * BIT_CLK) @(negedge clk);
    check("t4_break", {6'b0, pe8, fe8, bk8}, 9'b000000011);
    rx8 = 1'b1;
    hold_bits(2);
    send_frame(0, 9'h05A, 2'b00, 1'b0, 1'b1, 2'b00);
    check("t4_after_break", {1'b0, dout8}, 9'h05A);

    // Short low glitch on the idle line.
    rx8 = 1'b0;
    repeat (8) @(negedge clk);
    rx8 = 1'b1;
    hold_bits(2);

    // Reset during the data bits of 0x3C aborts the frame.
    rx8 = 1'b0;
    hold_bits(1);
    for (int i = 0; i < 3; i++) begin
      rx8 = (i >= 2);
      hold_bits(1);
    end
    rx8 = 1'b1;
    repeat (OVS) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    hold_bits(12);
    check("t6_dout8_zero", {1'b0, dout8}, 9'h000);
    check("t6_dout7_zero", {2'b0, dout7}, 9'h000);
    check("t6_flags_zero", {3'b0, pe8, fe8, bk8, pe7, fe7, bk7}, 9'd0);
    send_frame(0, 9'h081, 2'b00, 1'b0, 1'b1, 2'b00);
    check("t6_dout8_81", {1'b0, dout8}, 9'h081);

    check("dut8_frames_pending", 9'(q8.size()), 9'd0);
    check("dut7_frames_pending", 9'(q7.size()), 9'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
